sc_dmem_arbiter: RTL

- Two-requester arbiter and sequencer for the single-port data memory of the single-cycle computer.
- Port 0 is the CPU load/store path.
- Port 1 is a secondary master (program loader / display-refresh scanner).
- Serialises accesses, drives the memory-side address/data/write-enable, and returns read data with a one-cycle acknowledge per transaction.

---
 rtl/sc_dmem_arbiter_pkg.sv | 23 ++
 rtl/sc_dmem_arbiter_if.sv | 39 +++
 rtl/sc_dmem_arbiter_rr_pick2.sv | 29 ++
 rtl/sc_dmem_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/sc_dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester port indices and the read-latency counter helper.
package sc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

    // Requester indices; a grant is one bit wide.
    localparam logic P_CPU = 1'b0;
    localparam logic P_AUX = 1'b1;

    localparam int RD_LAT_MAX = 7;

    // Value loaded into the WAIT counter when a read leaves ISSUE.
    function automatic logic [2:0] wait_load(input int rd_lat);
        return 3'(rd_lat - 1);
    endfunction

endpackage

// File: rtl/sc_dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// slave: arbiter view; master: view of whatever drives requests and memory.
interface sc_dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, ack1, rdata,
        output mem_addr, mem_wdata, mem_we, busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, ack1, rdata,
        input  mem_addr, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/sc_dmem_arbiter_rr_pick2.sv
// Two-input selector. Default: round-robin, the port that did not win last
// time takes a tie. With SC_DMEM_ARB_CPU_PRIORITY_EN defined the CPU port
// always takes a tie and last_grant is ignored.
module sc_rr_pick2
    import sc_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    // Combinational winner selection.
    always_comb begin
        valid = req0 | req1;
        grant = P_CPU;
        if (req0 && req1) begin
`ifdef SC_DMEM_ARB_CPU_PRIORITY_EN
            grant = P_CPU;
`else
            grant = ~last_grant;
`endif
        end else if (req1) begin
            grant = P_AUX;
        end
    end

endmodule

// File: rtl/sc_dmem_arbiter.sv
// Arbiter/sequencer for the single-port data memory. Serialises CPU (port 0)
// and auxiliary (port 1) accesses through IDLE -> ISSUE -> [WAIT] -> ACK.
// Optional macro SC_DMEM_ARB_CPU_PRIORITY_EN selects fixed CPU priority
// instead of round-robin (handled in sc_rr_pick2).
module sc_dmem_arbiter
    import sc_arb_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
)(
    input  logic              clock,
    input  logic              resetn,
    sc_dmem_arbiter_if.slave  bus
);

    arb_state_e    state;
    logic          last_grant;
    logic          gnt_q;
    logic          we_q;
    logic [2:0]    cnt;

    logic          ack0_q, ack1_q, mem_we_q, busy_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q, rdata_q;

    logic          pick_gnt, pick_vld;

    sc_rr_pick2 u_pick (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_grant (last_grant),
        .grant      (pick_gnt),
        .valid      (pick_vld)
    );

    // Sequencer: all outputs are registered. The memory-side address and
    // write-data registers double as the latch for the selected request,
    // so they hold steady through WAIT and ACK.
    // A read spends RD_LAT-1 cycles in WAIT: the counter is loaded with
    // RD_LAT-1 and WAIT is left on the cycle it decrements to zero, so the
    // ACK edge is exactly RD_LAT edges after entering ISSUE.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            last_grant  <= P_AUX;
            gnt_q       <= P_CPU;
            we_q        <= 1'b0;
            cnt         <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            mem_we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q       <= pick_gnt;
                        last_grant  <= pick_gnt;
                        we_q        <= pick_gnt ? bus.we1    : bus.we0;
                        mem_we_q    <= pick_gnt ? bus.we1    : bus.we0;
                        mem_addr_q  <= pick_gnt ? bus.addr1  : bus.addr0;
                        mem_wdata_q <= pick_gnt ? bus.wdata1 : bus.wdata0;
                        busy_q      <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_q || RD_LAT == 1) begin
                        ack0_q <= (gnt_q == P_CPU);
                        ack1_q <= (gnt_q == P_AUX);
                        if (!we_q)
                            rdata_q <= bus.mem_rdata;
                        state <= ACK;
                    end else begin
                        cnt   <= wait_load(RD_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        ack0_q  <= (gnt_q == P_CPU);
                        ack1_q  <= (gnt_q == P_AUX);
                        rdata_q <= bus.mem_rdata;
                        state   <= ACK;
                    end
                end
                ACK: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.busy      = busy_q;

endmodule
